// File: rtl/rec_digit_collector.sv
// -----------------------------------------------------------------------------
// rec_digit_collector
//
// Collects redundant digits arriving serially (MSB first, one per handshake)
// and presents a complete parallel digit vector (S1, S0) to the 17-digit
// redundant prefix network. It is double-buffered: the shift register builds
// frame N+1 while the output register holds frame N.
//
// Optional feature macro: REC_CODE_CHECK_EN
//   defined   : code {d1,d0} = 2'b11 is illegal. It is stored as 2'b00 and
//               flags the frame through vec_err.
//   undefined : all codes pass unchanged and vec_err stays 0.
//
// Parameters
//   NDIG : digits per full frame (the width of S1/S0)
//   LW   : width of vec_len and of the digit counter (2**LW > NDIG)
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   d_valid    : input digit valid
//   d_ready    : collector accepts a digit this cycle
//   d1, d0     : digit code bits (d1 -> S1 plane, d0 -> S0 plane)
//   d_last     : final digit of a (possibly short) frame
//   vec_valid  : output vector valid
//   vec_ready  : downstream consumes the vector
//   S1, S0     : digit planes; index 0 = last digit received
//   vec_len    : number of digits in the presented frame (1..NDIG)
//   vec_err    : presented frame contained an illegal code
// -----------------------------------------------------------------------------
module rec_digit_collector #(
    parameter int NDIG = 17,
    parameter int LW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic            d1,
    input  logic            d0,
    input  logic            d_last,
    output logic            vec_valid,
    input  logic            vec_ready,
    output logic [NDIG-1:0] S1,
    output logic [NDIG-1:0] S0,
    output logic [LW-1:0]   vec_len,
    output logic            vec_err
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t          state;
    logic [NDIG-1:0] sh1;
    logic [NDIG-1:0] sh0;
    logic [LW-1:0]   cnt;
    logic [LW-1:0]   hold_len;
    logic            frame_err;

    logic            illegal;
    logic [1:0]      code;
    logic            accept;
    logic            complete;
    logic            out_free;
    logic [NDIG-1:0] nxt1;
    logic [NDIG-1:0] nxt0;
    logic [LW-1:0]   nxt_len;
    logic            nxt_err;

    // An illegal code enters the shift register as a zero digit.
    function automatic logic [1:0] sanitize_code(input logic c1, input logic c0,
                                                 input logic bad);
        return bad ? 2'b00 : {c1, c0};
    endfunction

`ifdef REC_CODE_CHECK_EN
    assign illegal = d1 & d0;
`else
    assign illegal = 1'b0;
`endif

    assign code     = sanitize_code(d1, d0, illegal);

    // Held low during reset so nothing is accepted while state is forced.
    assign d_ready  = (state == COLLECT) && !rst;
    assign accept   = d_valid && d_ready;
    assign complete = accept && (d_last || (cnt == LW'(NDIG - 1)));

    // The output register can take a new frame if it is empty or is being
    // drained on this same edge (no bubble between frames).
    assign out_free = !vec_valid || vec_ready;

    // Shifting left from a zeroed register right-aligns short frames.
    assign nxt1     = {sh1[NDIG-2:0], code[1]};
    assign nxt0     = {sh0[NDIG-2:0], code[0]};
    assign nxt_len  = cnt + LW'(1);
    assign nxt_err  = frame_err | illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            sh1       <= '0;
            sh0       <= '0;
            cnt       <= '0;
            hold_len  <= '0;
            frame_err <= 1'b0;
            S1        <= '0;
            S0        <= '0;
            vec_len   <= '0;
            vec_err   <= 1'b0;
            vec_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    // Drain; overridden below when a frame lands on this edge.
                    if (vec_valid && vec_ready) begin
                        vec_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (complete) begin
                            cnt <= '0;
                            if (out_free) begin
                                S1        <= nxt1;
                                S0        <= nxt0;
                                vec_len   <= nxt_len;
                                vec_err   <= nxt_err;
                                vec_valid <= 1'b1;
                                sh1       <= '0;
                                sh0       <= '0;
                                frame_err <= 1'b0;
                            end else begin
                                // Park the finished frame in the shift register.
                                sh1       <= nxt1;
                                sh0       <= nxt0;
                                hold_len  <= nxt_len;
                                frame_err <= nxt_err;
                                state     <= HOLD;
                            end
                        end else begin
                            sh1       <= nxt1;
                            sh0       <= nxt0;
                            cnt       <= nxt_len;
                            frame_err <= nxt_err;
                        end
                    end
                end

                HOLD: begin
                    // vec_valid is necessarily 1 here and stays 1.
                    if (vec_ready) begin
                        S1        <= sh1;
                        S0        <= sh0;
                        vec_len   <= hold_len;
                        vec_err   <= frame_err;
                        sh1       <= '0;
                        sh0       <= '0;
                        frame_err <= 1'b0;
                        state     <= COLLECT;
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rec_digit_collector.sv
// -----------------------------------------------------------------------------
// tb_rec_digit_collector
//
// Table-driven frame vectors, hand-written multi-cycle sequences
// (backpressure, same-edge drain, mid-frame reset, illegal code) and a
// randomized phase. Every cycle is also compared against a frame-level
// reference model built from digit queues.
// -----------------------------------------------------------------------------
module tb_rec_digit_collector;

    localparam int NDIG = 17;
    localparam int LW   = 5;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            d_valid   = 1'b0;
    logic            d1        = 1'b0;
    logic            d0        = 1'b0;
    logic            d_last    = 1'b0;
    logic            vec_ready = 1'b0;
    logic            d_ready;
    logic            vec_valid;
    logic [NDIG-1:0] S1;
    logic [NDIG-1:0] S0;
    logic [LW-1:0]   vec_len;
    logic            vec_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    rec_digit_collector #(.NDIG(NDIG), .LW(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d1        (d1),
        .d0        (d0),
        .d_last    (d_last),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .S1        (S1),
        .S0        (S0),
        .vec_len   (vec_len),
        .vec_err   (vec_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (frame level) ----------------
    bit              m_q1[$];
    bit              m_q0[$];
    bit              m_cerr;
    bit              m_pend;
    logic [NDIG-1:0] m_p1, m_p0;
    logic [LW-1:0]   m_plen;
    bit              m_perr;
    bit              m_ov;
    logic [NDIG-1:0] m_o1, m_o0;
    logic [LW-1:0]   m_olen;
    bit              m_oerr;

    task automatic model_reset();
        m_q1.delete();
        m_q0.delete();
        m_cerr = 0;
        m_pend = 0;
        m_p1 = '0; m_p0 = '0; m_plen = '0; m_perr = 0;
        m_ov = 0;
        m_o1 = '0; m_o0 = '0; m_olen = '0; m_oerr = 0;
    endtask

    task automatic model_step(input logic dv, input logic a, input logic b,
                              input logic last, input logic vr);
        bit acc, free, bad, c1, c0;
        int k;
        logic [NDIG-1:0] f1, f0;
        acc  = dv && !m_pend;
        free = !m_ov || vr;
        if (m_pend) begin
            if (vr) begin
                m_o1 = m_p1; m_o0 = m_p0; m_olen = m_plen; m_oerr = m_perr;
                m_pend = 0;
            end
        end else begin
            if (m_ov && vr) m_ov = 0;
            if (acc) begin
                c1 = a; c0 = b; bad = 0;
`ifdef REC_CODE_CHECK_EN
                if (a && b) begin c1 = 0; c0 = 0; bad = 1; end
`endif
                m_q1.push_back(c1);
                m_q0.push_back(c0);
                m_cerr = m_cerr | bad;
                if (last || m_q1.size() == NDIG) begin
                    k  = m_q1.size();
                    f1 = '0;
                    f0 = '0;
                    // First digit received is most significant.
                    for (int i = 0; i < k; i++) begin
                        f1[k-1-i] = m_q1[i];
                        f0[k-1-i] = m_q0[i];
                    end
                    if (free) begin
                        m_o1 = f1; m_o0 = f0; m_olen = LW'(k); m_oerr = m_cerr;
                        m_ov = 1;
                    end else begin
                        m_p1 = f1; m_p0 = f0; m_plen = LW'(k); m_perr = m_cerr;
                        m_pend = 1;
                    end
                    m_q1.delete();
                    m_q0.delete();
                    m_cerr = 0;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_cycle();
        logic [41:0] act, exp;
        act = {d_ready, vec_valid, S1, S0, vec_len, vec_err};
        exp = {~m_pend, m_ov, m_o1, m_o0, m_olen, m_oerr};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL model_cycle_%0d: got {rdy,vld,S1,S0,len,err}=%h required %h",
                     cyc, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(d_valid, d1, d0, d_last, vec_ready);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic send(input logic a, input logic b, input logic last);
        d_valid = 1'b1; d1 = a; d0 = b; d_last = last;
        tick();
    endtask

    task automatic idle();
        d_valid = 1'b0; d_last = 1'b0;
        tick();
    endtask

    // ---------------- frame vector table ----------------
    typedef struct {
        int              k;
        bit              use_last;
        logic [NDIG-1:0] in1;   // bit i = d1 of the i-th digit sent
        logic [NDIG-1:0] in0;
        logic [NDIG-1:0] e1;
        logic [NDIG-1:0] e0;
        logic [LW-1:0]   elen;
        logic            eerr;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{17, 1'b0, 17'h00001, 17'h1FFFE, 17'h10000, 17'h0FFFF, 5'd17, 1'b0};
`ifdef REC_CODE_CHECK_EN
        tbl[1] = '{ 3, 1'b1, 17'h00005, 17'h00006, 17'h00004, 17'h00002, 5'd3, 1'b1};
`else
        tbl[1] = '{ 3, 1'b1, 17'h00005, 17'h00006, 17'h00005, 17'h00003, 5'd3, 1'b0};
`endif
        tbl[2] = '{ 1, 1'b1, 17'h00000, 17'h00001, 17'h00000, 17'h00001, 5'd1, 1'b0};
        tbl[3] = '{ 4, 1'b1, 17'h00003, 17'h00004, 17'h0000C, 17'h00002, 5'd4, 1'b0};
        tbl[4] = '{ 5, 1'b1, 17'h00001, 17'h00010, 17'h00010, 17'h00001, 5'd5, 1'b0};
        tbl[5] = '{17, 1'b1, 17'h15555, 17'h00000, 17'h15555, 17'h00000, 5'd17, 1'b0};
        tbl[6] = '{16, 1'b1, 17'h00001, 17'h08000, 17'h08000, 17'h00001, 5'd16, 1'b0};

        model_reset();

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {58'd0, d_ready, vec_valid, S1 != 0, S0 != 0, vec_len != 0, vec_err},
              64'd0);
        rst = 1'b0;
        vec_ready = 1'b1;

        // ---- table frames, back to back, downstream always ready ----
        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < tbl[t].k; i++) begin
                send(tbl[t].in1[i], tbl[t].in0[i], tbl[t].use_last && (i == tbl[t].k - 1));
            end
            check($sformatf("table_frame_%0d", t),
                  {23'd0, vec_valid, S1, S0, vec_len, vec_err},
                  {23'd0, 1'b1, tbl[t].e1, tbl[t].e0, tbl[t].elen, tbl[t].eerr});
        end
        idle();
        check("drain_no_pending", {63'd0, vec_valid}, 64'd0);

        // ---- backpressure: two full frames with downstream stalled ----
        vec_ready = 1'b0;
        for (int i = 0; i < NDIG; i++) send(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NDIG; i++) send(1'b0, 1'b1, 1'b0);
        check("bp_ready_low_after_34", {63'd0, d_ready}, 64'd0);
        check("bp_frame1_held", {24'd0, vec_valid, S1, S0, vec_len},
              {24'd0, 1'b1, 17'h1FFFF, 17'h00000, 5'd17});
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
        check("bp_frame1_stable", {23'd0, d_ready, vec_valid, S1, S0, vec_len},
              {23'd0, 1'b0, 1'b1, 17'h1FFFF, 17'h00000, 5'd17});
        d_valid = 1'b0;
        vec_ready = 1'b1;
        idle();
        check("bp_frame2_release", {23'd0, d_ready, vec_valid, S1, S0, vec_len},
              {23'd0, 1'b1, 1'b1, 17'h00000, 17'h1FFFF, 5'd17});
        idle();
        check("bp_drain_keeps_fields", {29'd0, vec_valid, S1, S0},
              {29'd0, 1'b0, 17'h00000, 17'h1FFFF});

        // ---- same-edge drain: new frame lands as the old one is consumed ----
        vec_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        check("sd_frame_a", {24'd0, vec_valid, S1, S0, vec_len},
              {24'd0, 1'b1, 17'h00002, 17'h00001, 5'd2});
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        vec_ready = 1'b1;
        send(1'b1, 1'b0, 1'b1);
        check("sd_frame_b_no_bubble", {24'd0, vec_valid, S1, S0, vec_len},
              {24'd0, 1'b1, 17'h00003, 17'h00004, 5'd3});
        idle();

        // ---- asynchronous reset mid-frame ----
        vec_ready = 1'b0;
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 1'b0);
        d_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {21'd0, d_ready, vec_valid, S1, S0, vec_len, vec_err},
              64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        vec_ready = 1'b1;
        for (int i = 0; i < NDIG; i++) send(1'b0, 1'b1, 1'b0);
        check("post_reset_no_residue", {24'd0, vec_valid, S1, S0, vec_len},
              {24'd0, 1'b1, 17'h00000, 17'h1FFFF, 5'd17});

        // ---- illegal code at position 4, then a clean frame ----
        for (int i = 0; i < NDIG; i++) send(1'b1, (i == 12) ? 1'b1 : 1'b0, 1'b0);
`ifdef REC_CODE_CHECK_EN
        check("code_err_frame", {28'd0, vec_valid, S1, S0, vec_err},
              {28'd0, 1'b1, 17'h1FFEF, 17'h00000, 1'b1});
`else
        check("code_err_frame", {28'd0, vec_valid, S1, S0, vec_err},
              {28'd0, 1'b1, 17'h1FFFF, 17'h00010, 1'b0});
`endif
        for (int i = 0; i < NDIG; i++) send(1'b0, 1'b1, 1'b0);
        check("code_clean_frame", {28'd0, vec_valid, S1, S0, vec_err},
              {28'd0, 1'b1, 17'h00000, 17'h1FFFF, 1'b0});

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 3000; n++) begin
            d_valid   = ($urandom_range(0, 9) < 7);
            d1        = ($urandom_range(0, 1) != 0);
            d0        = ($urandom_range(0, 1) != 0);
            d_last    = ($urandom_range(0, 7) == 0);
            vec_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        d_valid = 1'b0;
        d_last  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
